decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 68 ++++++
 rtl/decode_stage_rv_decode.sv | 126 ++++++++++++
 rtl/decode_stage.sv | 143 ++++++++++++++
 tb/tb_decode_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared types for the decode stage.
//   alu_op_e       - ALU operation selected by the decoder
//   stage_state_e  - RUN/HALT state of the decode stage
//   instruction_t  - decoded instruction payload handed to execute
//   opcode/funct constants and immediate sign-extension helpers
// The immediate is carried at the widest legal XLEN (64) and is always fully
// sign-extended, so its low XLEN bits are the XLEN-wide immediate for either
// legal XLEN.
package decode_stage_pkg;

    localparam int IMM_W = 64;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } alu_op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } stage_state_e;

    typedef struct packed {
        alu_op_e          op;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic             has_immediate;
        logic [IMM_W-1:0] immediate;
        logic             is_ebreak;
    } instruction_t;

    function automatic logic [IMM_W-1:0] sext12(input logic [11:0] v);
        return {{(IMM_W-12){v[11]}}, v};
    endfunction

    function automatic logic [IMM_W-1:0] sext32(input logic [31:0] v);
        return {{(IMM_W-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_rv_decode.sv
// rv_decode: purely combinational RV decoder for the supported subset
// (R-type ALU, I-type ALU, LUI, EBREAK).
//   instr   - raw 32-bit instruction
//   dec     - decoded payload; all-zero (ADD, no registers) when illegal
//   illegal - high for every encoding outside the supported subset
module rv_decode
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]  instr,
    output instruction_t dec,
    output logic         illegal
);

    logic [6:0]   opcode_s;
    logic [2:0]   f3_s;
    logic [6:0]   f7_s;
    logic         sh_base_s;
    logic         sh_alt_s;
    logic [5:0]   shamt_s;
    logic         ok_s;
    instruction_t dec_s;

    assign opcode_s = instr[6:0];
    assign f3_s     = instr[14:12];
    assign f7_s     = instr[31:25];

    // Shift-immediate qualification: RV64 borrows instr[25] as shamt bit 5.
    always_comb begin
        if (XLEN == 64) begin
            sh_base_s = (instr[31:26] == 6'b000000);
            sh_alt_s  = (instr[31:26] == 6'b010000);
            shamt_s   = instr[25:20];
        end else begin
            sh_base_s = (f7_s == F7_BASE);
            sh_alt_s  = (f7_s == F7_ALT);
            shamt_s   = {1'b0, instr[24:20]};
        end
    end

    // Field extraction and operation selection; ok_s marks a supported encoding.
    always_comb begin
        dec_s = '0;
        ok_s  = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                dec_s.rd  = instr[11:7];
                dec_s.rs1 = instr[19:15];
                dec_s.rs2 = instr[24:20];
                if (f7_s == F7_BASE) begin
                    ok_s = 1'b1;
                    case (f3_s)
                        F3_ADD_SUB: dec_s.op = OP_ADD;
                        F3_SLL:     dec_s.op = OP_SLL;
                        F3_SLT:     dec_s.op = OP_SLT;
                        F3_SLTU:    dec_s.op = OP_SLTU;
                        F3_XOR:     dec_s.op = OP_XOR;
                        F3_SR:      dec_s.op = OP_SRL;
                        F3_OR:      dec_s.op = OP_OR;
                        F3_AND:     dec_s.op = OP_AND;
                        default:    ok_s     = 1'b0;
                    endcase
                end else if ((f7_s == F7_ALT) && (f3_s == F3_ADD_SUB)) begin
                    dec_s.op = OP_SUB;
                    ok_s     = 1'b1;
                end else if ((f7_s == F7_ALT) && (f3_s == F3_SR)) begin
                    dec_s.op = OP_SRA;
                    ok_s     = 1'b1;
                end else begin
                    ok_s = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec_s.rd            = instr[11:7];
                dec_s.rs1           = instr[19:15];
                dec_s.has_immediate = 1'b1;
                dec_s.immediate     = sext12(instr[31:20]);
                ok_s                = 1'b1;
                case (f3_s)
                    F3_ADD_SUB: dec_s.op = OP_ADD;
                    F3_SLT:     dec_s.op = OP_SLT;
                    F3_SLTU:    dec_s.op = OP_SLTU;
                    F3_XOR:     dec_s.op = OP_XOR;
                    F3_OR:      dec_s.op = OP_OR;
                    F3_AND:     dec_s.op = OP_AND;
                    F3_SLL: begin
                        dec_s.op        = OP_SLL;
                        dec_s.immediate = IMM_W'(shamt_s);
                        ok_s            = sh_base_s;
                    end
                    F3_SR: begin
                        dec_s.immediate = IMM_W'(shamt_s);
                        if (sh_base_s) begin
                            dec_s.op = OP_SRL;
                        end else if (sh_alt_s) begin
                            dec_s.op = OP_SRA;
                        end else begin
                            ok_s = 1'b0;
                        end
                    end
                    default: ok_s = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec_s.rd            = instr[11:7];
                dec_s.has_immediate = 1'b1;
                dec_s.immediate     = sext32({instr[31:12], 12'h000});
                ok_s                = 1'b1;
            end
            OPC_SYSTEM: begin
                if (instr == INSTR_EBREAK) begin
                    dec_s.is_ebreak = 1'b1;
                    ok_s            = 1'b1;
                end else begin
                    ok_s = 1'b0;
                end
            end
            default: ok_s = 1'b0;
        endcase
    end

    assign dec     = ok_s ? dec_s : '0;
    assign illegal = ~ok_s;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: buffered decode stage between fetch and execute.
//   clk, rst_n                        - clock, async active-low reset
//   in_valid/in_ready/in_instr/in_pc  - fetch-side handshake and payload
//   out_valid/out_ready/out_instr/out_pc - execute-side handshake and payload
//   flush   - discard all buffered entries (and any same-cycle push)
//   resume  - leave HALT once the buffer has drained
//   halted  - stage is in HALT (no new input accepted)
//   illegal - illegal flag of the entry currently at the head
// Decoded entries are written into a DEPTH-entry circular buffer; the head
// entry drives out_* directly from registers, giving one cycle of latency.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output instruction_t    out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            flush,
    input  logic            resume,
    output logic            halted,
    output logic            illegal
);

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    function automatic logic ptr_inc(input logic p);
        return (DEPTH == 1) ? 1'b0 : ~p;
    endfunction

    instruction_t    dec_s;
    logic            dec_ill_s;
    stage_state_e    state_r, state_s;
    logic [1:0]      count_r, count_s;
    logic            rd_ptr_r, rd_ptr_s;
    logic            wr_ptr_r, wr_ptr_s;
    logic            push_s, pop_s, head_ill_s;
    logic            out_valid_r, halted_r, illegal_r;
    instruction_t    mem_instr_r [DEPTH];
    logic [XLEN-1:0] mem_pc_r    [DEPTH];
    logic [DEPTH-1:0] mem_ill_r;

    rv_decode #(.XLEN(XLEN)) u_rv_decode (
        .instr   (in_instr),
        .dec     (dec_s),
        .illegal (dec_ill_s)
    );

    // Flush wins over both sides: a flushed cycle neither stores nor retires.
    assign in_ready = rst_n && (count_r < DEPTH_C) && (state_r == ST_RUN);
    assign push_s   = in_valid && in_ready && !flush;
    assign pop_s    = (count_r != 2'd0) && out_ready && !flush;

    // Next occupancy, pointers and RUN/HALT state.
    always_comb begin
        count_s  = count_r;
        rd_ptr_s = rd_ptr_r;
        wr_ptr_s = wr_ptr_r;
        state_s  = state_r;
        if (flush) begin
            count_s  = 2'd0;
            rd_ptr_s = 1'b0;
            wr_ptr_s = 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + 2'd1;
                2'b01:   count_s = count_r - 2'd1;
                default: count_s = count_r;
            endcase
            if (push_s) wr_ptr_s = ptr_inc(wr_ptr_r);
            else        wr_ptr_s = wr_ptr_r;
            if (pop_s)  rd_ptr_s = ptr_inc(rd_ptr_r);
            else        rd_ptr_s = rd_ptr_r;
            case (state_r)
                ST_RUN: begin
                    if (push_s && (dec_s.is_ebreak || dec_ill_s)) state_s = ST_HALT;
                    else                                          state_s = ST_RUN;
                end
                ST_HALT: begin
                    if (resume && (count_r == 2'd0)) state_s = ST_RUN;
                    else                             state_s = ST_HALT;
                end
                default: state_s = ST_RUN;
            endcase
        end
    end

    // Illegal flag of the next head: the incoming entry when it lands in the head slot.
    always_comb begin
        if (count_s == 2'd0) begin
            head_ill_s = 1'b0;
        end else if (push_s && (wr_ptr_r == rd_ptr_s)) begin
            head_ill_s = dec_ill_s;
        end else begin
            head_ill_s = mem_ill_r[rd_ptr_s];
        end
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            count_r     <= 2'd0;
            rd_ptr_r    <= 1'b0;
            wr_ptr_r    <= 1'b0;
            out_valid_r <= 1'b0;
            halted_r    <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            rd_ptr_r    <= rd_ptr_s;
            wr_ptr_r    <= wr_ptr_s;
            out_valid_r <= (count_s != 2'd0);
            halted_r    <= (state_s == ST_HALT);
            illegal_r   <= head_ill_s;
        end
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_instr_r[wr_ptr_r] <= dec_s;
            mem_pc_r[wr_ptr_r]    <= in_pc;
            mem_ill_r[wr_ptr_r]   <= dec_ill_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_instr = mem_instr_r[rd_ptr_r];
    assign out_pc    = mem_pc_r[rd_ptr_r];
    assign halted    = halted_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         flush = 1'b0;
    logic         resume = 1'b0;
    logic [31:0]  in_instr = 32'h0;
    logic [31:0]  in_pc = 32'h0;
    logic         in_ready, out_valid, halted, illegal;
    instruction_t out_instr;
    logic [31:0]  out_pc;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .flush(flush), .resume(resume), .halted(halted), .illegal(illegal)
    );

    typedef struct packed {
        alu_op_e     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        has_imm;
        logic [63:0] imm;
        logic        ebreak;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   model_occ = 0;
    bit   model_halt = 1'b0;

    // funct3 -> operation for the base (funct7 = 0) encodings
    alu_op_e base_ops [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        bit ok;
        logic signed [11:0] i12;
        logic signed [31:0] u32;
        logic signed [63:0] wide;
        e = '0;
        ok = 1'b0;
        i12 = w[31:20];
        u32 = {w[31:12], 12'h000};
        if (w == 32'h0010_0073) begin
            e.ebreak = 1'b1;
            ok = 1'b1;
        end else if (w[6:0] == 7'h33) begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
            if (w[31:25] == 7'h00) begin
                e.op = base_ops[w[14:12]]; ok = 1'b1;
            end else if (w[31:25] == 7'h20 && w[14:12] == 3'd0) begin
                e.op = OP_SUB; ok = 1'b1;
            end else if (w[31:25] == 7'h20 && w[14:12] == 3'd5) begin
                e.op = OP_SRA; ok = 1'b1;
            end
        end else if (w[6:0] == 7'h13) begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.has_imm = 1'b1;
            wide = i12;
            e.imm = wide;
            if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                e.imm = 64'(w[24:20]);
                if (w[31:25] == 7'h00) begin
                    e.op = base_ops[w[14:12]]; ok = 1'b1;
                end else if (w[31:25] == 7'h20 && w[14:12] == 3'd5) begin
                    e.op = OP_SRA; ok = 1'b1;
                end
            end else begin
                e.op = base_ops[w[14:12]]; ok = 1'b1;
            end
        end else if (w[6:0] == 7'h37) begin
            e.rd = w[11:7]; e.has_imm = 1'b1;
            wide = u32;
            e.imm = wide;
            ok = 1'b1;
        end
        if (!ok) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [6:0] pick_f7();
        int k;
        logic [6:0] r;
        k = $urandom_range(0, 3);
        r = 7'($urandom);
        if (k < 2) return 7'h00;
        else if (k == 2) return 7'h20;
        else return r;
    endfunction

    function automatic logic [31:0] gen_instr();
        int k;
        logic [31:0] w;
        k = $urandom_range(0, 11);
        w = $urandom;
        case (k)
            0, 1, 2: begin w[6:0] = 7'h33; w[31:25] = pick_f7(); end
            3, 4, 5: begin
                w[6:0] = 7'h13;
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) w[31:25] = pick_f7();
            end
            6, 7: w[6:0] = 7'h37;
            8:    w = 32'h0010_0073;
            9:    w = 32'h0000_0073;
            default: ;
        endcase
        return w;
    endfunction

    // One clock of stimulus; model and handshake checks happen on the falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy,
                        input logic fl, input logic rs, output bit acc);
        exp_t e;
        bit exp_ready, pop;
        int occ_before;
        in_valid = v; in_instr = ins; in_pc = $urandom; out_ready = rdy; flush = fl; resume = rs;
        @(negedge clk);
        exp_ready = (model_occ < 2) && !model_halt;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(model_occ != 0));
        chk("halted", 64'(halted), 64'(model_halt));
        acc = v && exp_ready && !fl;
        pop = (model_occ != 0) && rdy && !fl;
        occ_before = model_occ;
        if (fl) begin
            model_occ = 0;
            sb_q.delete();
        end else begin
            if (acc) begin
                e = ref_decode(ins);
                e.pc = in_pc;
                sb_q.push_back(e);
                model_occ++;
                if (e.ebreak || e.ill) model_halt = 1'b1;
            end else if (model_halt && rs && occ_before == 0) begin
                model_halt = 1'b0;
            end
            if (pop) model_occ--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, rdy, 1'b0, 1'b0, acc);
    endtask

    task automatic send(input logic [31:0] ins, input logic rdy);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            step(1'b1, ins, rdy, 1'b0, 1'b0, acc);
            n++;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout: instr %08h not accepted in 20 cycles", ins);
        end
    endtask

    // Scoreboard monitor: head of the queue must be on out_* while out_valid.
    always @(negedge clk) begin
        if (rst_n && out_valid && !flush) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out: out_valid with no expected entry at %0t", $time);
            end else begin
                mon_e = sb_q[0];
                chk("op", 64'(out_instr.op), 64'(mon_e.op));
                chk("rd", 64'(out_instr.rd), 64'(mon_e.rd));
                chk("rs1", 64'(out_instr.rs1), 64'(mon_e.rs1));
                chk("rs2", 64'(out_instr.rs2), 64'(mon_e.rs2));
                chk("has_imm", 64'(out_instr.has_immediate), 64'(mon_e.has_imm));
                chk("imm", out_instr.immediate, mon_e.imm);
                chk("ebreak", 64'(out_instr.is_ebreak), 64'(mon_e.ebreak));
                chk("illegal", 64'(illegal), 64'(mon_e.ill));
                chk("pc", 64'(out_pc), 64'(mon_e.pc));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    logic [31:0] stall_list [5] = '{32'h00A580B3, 32'h40B50533, 32'h0015F613, 32'h00C7E6B3, 32'h0037D713};

    initial begin
        bit acc;
        bit v, r, f, s;
        // reset state
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_halted", 64'(halted), 64'd0);
        chk("reset_illegal", 64'(illegal), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // negative I-immediate, latency 1
        send(32'hFF60_0093, 1'b1);
        idle(2, 1'b1);

        // back-to-back with no bubbles
        step(1'b1, 32'h00A5_80B3, 1'b1, 1'b0, 1'b0, acc); chk("no_bubble0", 64'(in_ready), 64'd1);
        step(1'b1, 32'h4041_D113, 1'b1, 1'b0, 1'b0, acc); chk("no_bubble1", 64'(in_ready), 64'd1);
        step(1'b1, 32'h1234_52B7, 1'b1, 1'b0, 1'b0, acc); chk("no_bubble2", 64'(in_ready), 64'd1);
        idle(3, 1'b1);

        // stall: only two accepted, entries held, drained in order
        for (int i = 0; i < 5; i++) step(1'b1, stall_list[i], 1'b0, 1'b0, 1'b0, acc);
        idle(4, 1'b1);

        // EBREAK halts; NOP refused until resume with empty buffer
        send(32'h0010_0073, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b1, acc);
        send(32'h0000_0013, 1'b1);
        idle(2, 1'b1);

        // all-zero word is illegal and halts
        send(32'h0000_0000, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);

        // flush with two entries buffered
        send(32'h0010_8093, 1'b0);
        send(32'h0020_8113, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        idle(2, 1'b1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 2) == 0);
            step(v, gen_instr(), r, f, s, acc);
        end
        idle(3, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, acc);
        idle(1, 1'b1);

        // asynchronous reset mid-stream while halted with entries buffered
        send(32'h00A5_80B3, 1'b0);
        send(32'h0010_0073, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_halted", 64'(halted), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        model_occ = 0;
        model_halt = 1'b0;
        sb_q.delete();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; resume = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'hFF60_0093, 1'b1);
        idle(3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
